// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with valid/ready load handshake
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   load_valid  load_data is valid
//   load_ready  a word can be accepted this cycle (combinational)
//   load_data   WIDTH-bit word, sampled only on handshake
//   hold        pauses shifting while high
//   ser_out     serial data bit
//   ser_valid   ser_out carries a frame bit this cycle
//   frame_start first bit of a frame
//   ser_last    final bit of a frame
// Define PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             ser_last
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_e;
  localparam bit PAR_ON = 1'b1;
  logic parity_q, parity_d;
`else
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam bit PAR_ON = 1'b0;
`endif
  state_e state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic frame_start_q, frame_start_d;
  logic ser_last_q, ser_last_d;
  logic data_end, last, accept;

  // cnt_q indexes the bit currently on ser_out; the register always holds the
  // unsent remainder of the word with the displayed bit at its head
  assign data_end = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`ifdef PARITY_EN
  assign last = (state_q == PAR);
`else
  assign last = data_end;
`endif
  assign load_ready  = (state_q == IDLE) || (last && !hold);
  assign accept      = load_valid && load_ready;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign ser_last    = ser_last_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    ser_last_d    = ser_last_q;
`ifdef PARITY_EN
    parity_d      = parity_q;
`endif
    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = load_data;
      cnt_d         = '0;
      ser_out_d     = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      ser_last_d    = 1'b0;
`ifdef PARITY_EN
      parity_d      = ^load_data;
`endif
    end else if (state_q != IDLE && hold) begin
      // frozen bit is reported invalid; markers stay for when hold releases
      ser_valid_d = 1'b0;
    end else if (last) begin
      state_d       = IDLE;
      cnt_d         = '0;
      ser_out_d     = 1'b0;
      ser_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      ser_last_d    = 1'b0;
    end
`ifdef PARITY_EN
    else if (data_end) begin
      state_d       = PAR;
      cnt_d         = cnt_q + CW'(1);
      ser_out_d     = parity_q;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b0;
      ser_last_d    = 1'b1;
    end
`endif
    else if (state_q == SHIFT) begin
      shreg_d       = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d         = cnt_q + CW'(1);
      ser_out_d     = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b0;
      ser_last_d    = !PAR_ON && (cnt_q == CW'(WIDTH - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      ser_last_q    <= 1'b0;
`ifdef PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      ser_last_q    <= ser_last_d;
`ifdef PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scenario tests plus random traffic against a frame-level model
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic clk = 1'b0, reset = 1'b0, load_valid = 1'b0, hold = 1'b0;
  logic [W-1:0] load_data = '0;
  logic load_ready, ser_out, ser_valid, frame_start, ser_last;
  logic [4:0] obs, e;
  int checks = 0, errors = 0;
  int m_pos = -1, m_accepts = 0;
  bit m_valid, m_out, m_fs, m_sl;
  bit m_frame [0:W];

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .hold(hold), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .ser_last(ser_last)
  );

  always #5 clk = ~clk;
  assign obs = {load_ready, ser_valid, ser_out, frame_start, ser_last};

  // frame as transmitted: data MSB first, then parity when enabled
  function automatic logic [31:0] frame_bits(input logic [W-1:0] d);
`ifdef PARITY_EN
    return {23'd0, d, ^d};
`else
    return {24'd0, d};
`endif
  endfunction

  // one clock: model consumes the inputs seen at the edge, expected outputs returned at negedge
  task automatic tick(output logic [4:0] exp);
    bit rdy, upd;
    rdy = (m_pos < 0) || (m_pos == FL - 1 && !hold);
    upd = 1'b1;
    @(posedge clk);
    if (!reset) m_pos = -1;
    else if (load_valid && rdy) begin
      for (int i = 0; i < W; i++) m_frame[i] = load_data[W-1-i];
      m_frame[W] = ^load_data;
      m_pos = 0;
      m_accepts++;
    end else if (m_pos >= 0 && hold) begin
      m_valid = 1'b0;
      upd = 1'b0;
    end else if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FL) m_pos = -1;
    end
    if (m_pos < 0) {m_valid, m_out, m_fs, m_sl} = 4'b0;
    else begin
      m_out = m_frame[m_pos];
      if (upd) {m_valid, m_fs, m_sl} = {1'b1, m_pos == 0, m_pos == FL - 1};
    end
    @(negedge clk);
    exp = {(m_pos < 0) || (m_pos == FL - 1 && !hold), m_valid, m_out, m_fs, m_sl};
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; load_data = W'($urandom);
    for (int c = 0; c < 2; c++) begin
      tick(e); checks++;
      if (obs !== e || obs !== 5'b10000) begin errors++; $display("FAIL reset cyc%0d got %b exp %b", c, obs, e); end
    end
    reset = 1'b1; load_valid = 1'b0;
    tick(e); checks++;
    if (obs !== 5'b10000) begin errors++; $display("FAIL reset_release got %b exp %b", obs, 5'b10000); end
  endtask

  task automatic test_single();
    logic [31:0] acc = 0; int nv = 0;
    load_valid = 1'b1; load_data = 8'hA5;
    for (int c = 0; c < FL + 2; c++) begin
      tick(e); load_valid = 1'b0; checks++;
      if (obs !== e) begin errors++; $display("FAIL single cyc%0d got %b exp %b", c, obs, e); end
      if (ser_valid) begin acc = {acc[30:0], ser_out}; nv++; end
      if (c == 0) begin checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", frame_start); end end
      if (c == FL - 1) begin checks++; if (ser_last !== 1'b1) begin errors++; $display("FAIL single_last got %b exp 1", ser_last); end end
      if (c == FL) begin checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL single_end got %b exp 0", ser_valid); end end
    end
    checks++;
    if (acc !== frame_bits(8'hA5) || nv != FL) begin errors++; $display("FAIL single_word got %h/%0d exp %h/%0d", acc, nv, frame_bits(8'hA5), FL); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc = 0, want; int nv = 0, first = -1, lastc = -1, base;
    base = m_accepts;
    load_valid = 1'b1; load_data = 8'h81;
    for (int c = 0; c < 2 * FL + 4; c++) begin
      tick(e); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b cyc%0d got %b exp %b", c, obs, e); end
      load_data = 8'h7E;
      if (m_accepts - base >= 2) load_valid = 1'b0;
      if (ser_valid) begin acc = {acc[30:0], ser_out}; nv++; if (first < 0) first = c; lastc = c; end
    end
    want = (frame_bits(8'h81) << FL) | frame_bits(8'h7E);
    checks++;
    if (acc !== want || nv != 2 * FL || lastc - first + 1 != nv) begin
      errors++; $display("FAIL b2b_stream got %h n%0d span%0d exp %h n%0d", acc, nv, lastc - first + 1, want, 2 * FL);
    end
  endtask

  task automatic test_hold();
    logic [31:0] acc = 0; int nv = 0, first = -1, lastc = -1, waited = 0;
    load_valid = 1'b1; load_data = 8'hF0;
    for (int c = 0; c < 3 * FL + 6; c++) begin
      if (m_pos == 2 && waited == 0) begin hold = 1'b1; waited = 1; end
      else if (waited > 0 && waited < 3) waited++;
      else if (waited == 3) begin hold = 1'b0; waited = 4; end
      tick(e); load_valid = 1'b0; checks++;
      if (obs !== e) begin errors++; $display("FAIL hold cyc%0d got %b exp %b", c, obs, e); end
      if (ser_valid) begin acc = {acc[30:0], ser_out}; nv++; if (first < 0) first = c; lastc = c; end
    end
    hold = 1'b0;
    checks++;
    if (waited != 4 || acc !== frame_bits(8'hF0) || nv != FL || lastc - first + 1 != FL + 3) begin
      errors++; $display("FAIL hold_stream got %h n%0d span%0d exp %h n%0d span%0d", acc, nv, lastc - first + 1, frame_bits(8'hF0), FL, FL + 3);
    end
  endtask

  task automatic test_reset_mid();
    int nv = 0;
    load_valid = 1'b1; load_data = 8'hFF;
    for (int c = 0; c < 10 && m_pos != 4; c++) begin tick(e); load_valid = 1'b0; end
    checks++;
    if (m_pos != 4) begin errors++; $display("FAIL rstmid_timeout got pos %0d exp 4", m_pos); end
    reset = 1'b0;
    tick(e); reset = 1'b1; checks++;
    if (obs !== e || obs !== 5'b10000) begin errors++; $display("FAIL rstmid got %b exp %b", obs, 5'b10000); end
    for (int c = 0; c < FL; c++) begin
      tick(e); checks++;
      if (obs !== e) begin errors++; $display("FAIL rstmid_after cyc%0d got %b exp %b", c, obs, e); end
      if (ser_valid) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL rstmid_bits got %0d exp 0", nv); end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2] = '{8'h07, 8'h03};
    logic [8:0] want [2] = '{9'b000001111, 9'b000000110};
    for (int k = 0; k < 2; k++) begin
      logic [8:0] acc = 0; int nv = 0;
      load_valid = 1'b1; load_data = words[k];
      for (int c = 0; c < FL + 1; c++) begin
        tick(e); load_valid = 1'b0; checks++;
        if (obs !== e) begin errors++; $display("FAIL parity%0d cyc%0d got %b exp %b", k, c, obs, e); end
        if (ser_valid) begin acc = {acc[7:0], ser_out}; nv++; end
        if (c == W) begin checks++; if (ser_last !== 1'b1) begin errors++; $display("FAIL parity_last got %b exp 1", ser_last); end end
      end
      checks++;
      if (acc !== want[k] || nv != 9) begin errors++; $display("FAIL parity_word%0d got %b exp %b", k, acc, want[k]); end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      load_valid = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 60) != 0);
      load_data = W'($urandom);
      tick(e); checks++;
      if (obs !== e) begin errors++; $display("FAIL random cyc%0d got %b exp %b", c, obs, e); end
    end
    reset = 1'b1; load_valid = 1'b0; hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
